// File: rtl/reuse_ptr_ctrl.sv
// Serpentine row-walk pointer controller for the CCM register_array row-reuse buffers.
// One shared address drives both arrays: old row data is read where the new row is written.
//
// state  | meaning
// IDLE   | waiting for en with a legal col; flags cfg_err when col < 4
// RIGHT  | writing an even row, wr_ptr counting up to span
// PAUSE  | single idle cycle at the turn-around column
// LEFT   | writing an odd row, wr_ptr counting down to 0
// FINISH | all rows written, done held until en drops
module reuse_ptr_ctrl #(
   parameter int PTR_W = 9,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [8:0]       col,
   output logic [PTR_W-1:0] wr_ptr,
   output logic             wr_en,
   output logic [PTR_W-1:0] rd_ptr,
   output logic             rd_valid,
   output logic [CNT_W-1:0] row_cnt,
   output logic             done,
   output logic             cfg_err
);

   typedef enum logic [2:0] {IDLE, RIGHT, PAUSE, LEFT, FINISH} state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] wr_ptr_nxt;
   logic             wr_en_nxt;
   logic             rd_valid_nxt;
   logic [CNT_W-1:0] row_cnt_nxt;
   logic             done_nxt;
   logic             cfg_err_nxt;

   logic [8:0]       span;
   logic [8:0]       rows;
   logic [8:0]       row_inc9;
   logic             col_ok;
   logic             at_span;
   logic             at_zero;

   assign span     = col - 9'd3;
   assign rows     = col - 9'd2;
   assign row_inc9 = 9'(row_cnt) + 9'd1;
   assign col_ok   = (col >= 9'd4);
   assign at_span  = (9'(wr_ptr) == span);
   assign at_zero  = (wr_ptr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         wr_en    <= 1'b0;
         rd_valid <= 1'b0;
         row_cnt  <= '0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_ptr   <= wr_ptr_nxt;
         wr_en    <= wr_en_nxt;
         rd_valid <= rd_valid_nxt;
         row_cnt  <= row_cnt_nxt;
         done     <= done_nxt;
         cfg_err  <= cfg_err_nxt;
      end
   end

   // Read-before-write on the same address, so the read pointer is the write pointer.
   assign rd_ptr = wr_ptr;

   always_comb begin
      state_nxt    = state;
      wr_ptr_nxt   = wr_ptr;
      wr_en_nxt    = 1'b0;
      rd_valid_nxt = 1'b0;
      row_cnt_nxt  = row_cnt;
      done_nxt     = 1'b0;
      cfg_err_nxt  = 1'b0;

      if (!en) begin
         state_nxt   = IDLE;
         wr_ptr_nxt  = '0;
         row_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               row_cnt_nxt = '0;
               wr_ptr_nxt  = '0;
               if (col_ok) begin
                  state_nxt = RIGHT;
                  wr_en_nxt = 1'b1;
               end else begin
                  cfg_err_nxt = 1'b1;
               end
            end
            RIGHT, LEFT: begin
               if ((state == RIGHT) ? at_span : at_zero) begin
                  row_cnt_nxt = row_cnt + CNT_W'(1);
                  if (row_inc9 == rows) begin
                     state_nxt = FINISH;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = PAUSE;
                  end
               end else begin
                  wr_ptr_nxt   = (state == RIGHT) ? wr_ptr + PTR_W'(1) : wr_ptr - PTR_W'(1);
                  wr_en_nxt    = 1'b1;
                  rd_valid_nxt = (row_cnt != '0);
               end
            end
            PAUSE: begin
               // Odd row_cnt means an even row just finished, so the next row walks left.
               state_nxt    = row_cnt[0] ? LEFT : RIGHT;
               wr_en_nxt    = 1'b1;
               rd_valid_nxt = (row_cnt != '0);
            end
            FINISH: begin
               done_nxt = 1'b1;
            end
            default: begin
               state_nxt   = IDLE;
               wr_ptr_nxt  = '0;
               row_cnt_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reuse_ptr_ctrl.sv
// Directed bench for reuse_ptr_ctrl: serpentine walks, turn-around pauses,
// frame completion, config error, abort/restart and asynchronous reset.
module tb_reuse_ptr_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [8:0] col;
   logic [8:0] wr_ptr;
   logic       wr_en;
   logic [8:0] rd_ptr;
   logic       rd_valid;
   logic [7:0] row_cnt;
   logic       done;
   logic       cfg_err;

   int n_vec = 0;
   int n_err = 0;

   reuse_ptr_ctrl #(.PTR_W(9), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .col      (col),
      .wr_ptr   (wr_ptr),
      .wr_en    (wr_en),
      .rd_ptr   (rd_ptr),
      .rd_valid (rd_valid),
      .row_cnt  (row_cnt),
      .done     (done),
      .cfg_err  (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack_dut();
      return {2'b00, cfg_err, done, wr_en, rd_valid, row_cnt, wr_ptr, rd_ptr};
   endfunction

   // Waits one cycle, then compares every output against the expected tuple.
   task automatic expect_cyc(input string tag, input bit we, input int ptr, input bit rv,
                             input int rc, input bit dn);
      logic [31:0] exp;
      @(negedge clk);
      exp = {2'b00, 1'b0, dn, we, rv, 8'(rc), 9'(ptr), 9'(ptr)};
      chk(tag, pack_dut(), exp);
   endtask

   // Row-oriented reference: row r walks 0..span (even) or span..0 (odd),
   // followed by one pause at the end column or, after the last row, FINISH.
   task automatic walk_frame(input string tag, input int c, input int max_rows);
      int span_v;
      int rows_v;
      int end_ptr;
      span_v = c - 3;
      rows_v = c - 2;
      for (int r = 0; r < rows_v && r < max_rows; r++) begin
         for (int k = 0; k <= span_v; k++)
            expect_cyc(tag, 1'b1, (r % 2 == 0) ? k : span_v - k, (r > 0), r, 1'b0);
         end_ptr = (r % 2 == 0) ? span_v : 0;
         if (r + 1 < rows_v)
            expect_cyc({tag, "_pause"}, 1'b0, end_ptr, 1'b0, r + 1, 1'b0);
         else
            expect_cyc({tag, "_finish"}, 1'b0, end_ptr, 1'b0, r + 1, 1'b1);
      end
   endtask

   task automatic expect_zero(input string tag);
      @(negedge clk);
      chk(tag, pack_dut(), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      col   = 9'd0;
      repeat (2) @(negedge clk);
      chk("reset_vals", pack_dut(), 32'h0);
      rst_n = 1'b1;
      expect_zero("idle_en_low");

      // Full col=8 frame: 36 writes + 5 pauses, done on cycle 42.
      col = 9'd8;
      en  = 1'b1;
      walk_frame("col8", 8, 6);
      expect_cyc("col8_hold", 1'b0, 0, 1'b0, 6, 1'b1);
      expect_cyc("col8_hold", 1'b0, 0, 1'b0, 6, 1'b1);
      en = 1'b0;
      expect_zero("col8_off");

      // Smallest legal map.
      col = 9'd4;
      en  = 1'b1;
      expect_cyc("col4_w", 1'b1, 0, 1'b0, 0, 1'b0);
      expect_cyc("col4_w", 1'b1, 1, 1'b0, 0, 1'b0);
      expect_cyc("col4_pause", 1'b0, 1, 1'b0, 1, 1'b0);
      expect_cyc("col4_w", 1'b1, 1, 1'b1, 1, 1'b0);
      expect_cyc("col4_w", 1'b1, 0, 1'b1, 1, 1'b0);
      expect_cyc("col4_finish", 1'b0, 0, 1'b0, 2, 1'b1);
      expect_cyc("col4_hold", 1'b0, 0, 1'b0, 2, 1'b1);
      en = 1'b0;
      expect_zero("col4_off");

      // Illegal map size.
      col = 9'd3;
      en  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("col3_cfg_err", {29'd0, cfg_err, wr_en, done}, 32'b100);
      end
      en = 1'b0;
      expect_zero("col3_off");

      // Abort mid-row 2 at wr_ptr=3, then restart a fresh frame.
      col = 9'd8;
      en  = 1'b1;
      walk_frame("abort", 8, 2);
      for (int k = 0; k <= 3; k++)
         expect_cyc("abort_r2", 1'b1, k, 1'b1, 2, 1'b0);
      en = 1'b0;
      expect_zero("abort_idle");
      en = 1'b1;
      walk_frame("restart", 8, 1);
      en = 1'b0;
      expect_zero("restart_off");

      // Asynchronous reset in the middle of row 1.
      en = 1'b1;
      walk_frame("areset", 8, 1);
      expect_cyc("areset_r1", 1'b1, 5, 1'b1, 1, 1'b0);
      expect_cyc("areset_r1", 1'b1, 4, 1'b1, 1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("areset_async", pack_dut(), 32'h0);
      en = 1'b0;
      @(negedge clk);
      chk("areset_held", pack_dut(), 32'h0);
      rst_n = 1'b1;
      expect_zero("areset_release");

      // Wide map: right walk to 257, left walk back to 0.
      col = 9'd260;
      en  = 1'b1;
      walk_frame("col260", 260, 2);
      expect_cyc("col260_r2", 1'b1, 0, 1'b1, 2, 1'b0);
      en = 1'b0;
      expect_zero("col260_off");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
